// File: rtl/isp_pkg.sv
// Shared ISP definitions: Bayer phase codes, the centre-phase helper and
// the legal window-size range for the sliding-window blocks.
package isp_pkg;

    typedef enum logic [1:0] {
        BAYER_RGGB = 2'd0,
        BAYER_GRBG = 2'd1,
        BAYER_GBRG = 2'd2,
        BAYER_BGGR = 2'd3
    } bayer_e;

    localparam int K_MIN = 3;
    localparam int K_MAX = 7;

    // Moving one column flips bit 0 of the phase code, one row flips bit 1.
    function automatic logic [1:0] bayer_phase_at(input logic [1:0] start,
                                                  input logic       y_odd,
                                                  input logic       x_odd);
        return start ^ {y_odd, x_odd};
    endfunction

endpackage

// File: rtl/isp_line_mem.sv
// Single line buffer: DEPTH x DATA_W, combinational read, registered write.
// Addresses beyond DEPTH (only reachable with an illegal frame width) are ignored.
module isp_line_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2048,
    parameter int AW     = 12
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);
    localparam int AIW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AIW-1:0]    w_idx;
    logic              w_in_range;

    assign w_idx      = i_addr[AIW-1:0];
    assign w_in_range = int'(i_addr) < DEPTH;
    assign o_rdata    = w_in_range ? r_mem[w_idx] : '0;

    always_ff @(posedge clk) begin
        if (i_we && w_in_range) r_mem[w_idx] <= i_wdata;
    end

endmodule

// File: rtl/bayer_window_kxk.sv
// KxK sliding window over a raw Bayer raster stream with frame tracking,
// centre coordinates/phase, crop gating and frame/config error flags.
module bayer_window_kxk
    import isp_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int K      = 5,
    parameter int MAX_W  = 2048,
    parameter int CW     = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_W-1:0]     din,
    input  logic                  din_vld,
    input  logic                  din_sof,
    input  logic [CW-1:0]         h_active,
    input  logic [CW-1:0]         v_active,
    input  logic [1:0]            bayer_start,
    output logic [K*K*DATA_W-1:0] win_data,
    output logic                  win_vld,
    output logic [CW-1:0]         ctr_x,
    output logic [CW-1:0]         ctr_y,
    output logic [1:0]            ctr_phase,
    output logic                  win_eof,
    output logic                  frame_err,
    output logic                  cfg_err
);
    localparam int            R    = (K - 1) / 2;
    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [CW-1:0] KM1  = CW'(K - 1);
    localparam logic [CW-1:0] R_C  = CW'(R);

    if ((K % 2) == 0 || K < K_MIN || K > K_MAX) begin : g_bad_k
        $error("bayer_window_kxk: K must be odd and within 3..7");
    end

    logic [CW-1:0] r_x, r_y, r_w, r_h;
    logic          r_cfg_err;
    logic [K-1:0][K-1:0][DATA_W-1:0] r_win;

    logic [CW-1:0] w_cx, w_cy, w_w, w_h, w_ctr_x, w_ctr_y;
    logic          w_cnt_org, w_origin, w_last_x, w_last_y;
    logic          w_cfg_bad, w_cfg, w_in_win;
    logic [K-2:0][DATA_W-1:0] w_rd;
    logic [K-1:0][DATA_W-1:0] w_col;

    // SOF overrides the counters; a natural wrap to (0,0) also resamples sizes.
    assign w_cnt_org = (r_x == '0) && (r_y == '0);
    assign w_origin  = din_sof || w_cnt_org;
    assign w_cx      = din_sof ? '0 : r_x;
    assign w_cy      = din_sof ? '0 : r_y;
    assign w_w       = w_origin ? h_active : r_w;
    assign w_h       = w_origin ? v_active : r_h;
    assign w_last_x  = (w_cx == w_w - ONE);
    assign w_last_y  = (w_cy == w_h - ONE);

    assign w_cfg_bad = (int'(h_active) < K) || (int'(h_active) > MAX_W) ||
                       (int'(v_active) < K) || (int'(v_active) > MAX_W);
    assign w_cfg     = w_origin ? w_cfg_bad : r_cfg_err;
    assign w_in_win  = (w_cx >= KM1) && (w_cy >= KM1) && !w_cfg;
    assign w_ctr_x   = w_cx - R_C;
    assign w_ctr_y   = w_cy - R_C;

    for (genvar i = 0; i < K - 1; i++) begin : g_line
        isp_line_mem #(
            .DATA_W (DATA_W),
            .DEPTH  (MAX_W),
            .AW     (CW)
        ) u_line_mem (
            .clk     (clk),
            .i_we    (din_vld),
            .i_addr  (w_cx),
            .i_wdata ((i == 0) ? din : w_rd[(i == 0) ? 0 : i - 1]),
            .o_rdata (w_rd[i])
        );
        assign w_col[K-2-i] = w_rd[i];
    end
    assign w_col[K-1] = din;

    assign win_data = r_win;
    assign cfg_err  = r_cfg_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x       <= '0;
            r_y       <= '0;
            r_w       <= '0;
            r_h       <= '0;
            r_cfg_err <= 1'b0;
            r_win     <= '0;
            win_vld   <= 1'b0;
            win_eof   <= 1'b0;
            frame_err <= 1'b0;
            ctr_x     <= '0;
            ctr_y     <= '0;
            ctr_phase <= 2'd0;
        end else begin
            win_vld   <= 1'b0;
            win_eof   <= 1'b0;
            frame_err <= 1'b0;
            if (din_vld) begin
                if (w_origin) begin
                    r_w       <= h_active;
                    r_h       <= v_active;
                    r_cfg_err <= w_cfg_bad;
                end
                // Error when SOF lands off-origin or the origin arrives without SOF.
                frame_err <= din_sof ^ w_cnt_org;
                r_x <= w_last_x ? '0 : w_cx + ONE;
                if (w_last_x) r_y <= w_last_y ? '0 : w_cy + ONE;
                else          r_y <= w_cy;
                for (int r = 0; r < K; r++) begin
                    for (int c = 0; c < K - 1; c++) r_win[r][c] <= r_win[r][c+1];
                    r_win[r][K-1] <= w_col[r];
                end
                win_vld <= w_in_win;
                if (w_in_win) begin
                    ctr_x     <= w_ctr_x;
                    ctr_y     <= w_ctr_y;
                    ctr_phase <= bayer_phase_at(bayer_start, w_ctr_y[0], w_ctr_x[0]);
                    win_eof   <= w_last_x && w_last_y;
                end
            end
        end
    end

endmodule

// File: tb/tb_bayer_window_kxk.sv
// Scoreboard bench for bayer_window_kxk: a frame-image reference model pushes
// expected windows, a monitor pops and compares whenever win_vld is seen.
module tb_bayer_window_kxk;
    localparam int DATA_W = 8;
    localparam int K      = 5;
    localparam int MAX_W  = 2048;
    localparam int CW     = 12;
    localparam int R      = (K - 1) / 2;
    localparam int FW     = 16;
    localparam int FH     = 8;
    localparam int NW     = (FW - K + 1) * (FH - K + 1);

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [DATA_W-1:0]     din = '0;
    logic                  din_vld = 1'b0;
    logic                  din_sof = 1'b0;
    logic [CW-1:0]         h_active = '0;
    logic [CW-1:0]         v_active = '0;
    logic [1:0]            bayer_start = 2'd0;
    logic [K*K*DATA_W-1:0] win_data;
    logic                  win_vld;
    logic [CW-1:0]         ctr_x, ctr_y;
    logic [1:0]            ctr_phase;
    logic                  win_eof, frame_err, cfg_err;

    always #5 clk = ~clk;

    bayer_window_kxk #(.DATA_W(DATA_W), .K(K), .MAX_W(MAX_W), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .din_sof(din_sof),
        .h_active(h_active), .v_active(v_active), .bayer_start(bayer_start),
        .win_data(win_data), .win_vld(win_vld), .ctr_x(ctr_x), .ctr_y(ctr_y),
        .ctr_phase(ctr_phase), .win_eof(win_eof), .frame_err(frame_err), .cfg_err(cfg_err)
    );

    typedef struct {
        logic [K*K*DATA_W-1:0] data;
        logic [CW-1:0]         cx;
        logic [CW-1:0]         cy;
        logic [1:0]            ph;
        logic                  eof;
    } exp_t;

    exp_t q[$];
    int n_chk = 0, n_fail = 0;

    // Reference model: the frame image as received plus raster position.
    logic [DATA_W-1:0] img [0:63][0:63];
    int mx = 0, my = 0, mw = 0, mh = 0;
    bit mcfg = 0;
    bit exp_ferr = 0;

    int win_cnt, eof_cnt, ferr_cnt;
    int first_cx, first_cy, first_d00, first_dkk, eof_cx, eof_cy;
    int ph_seen [0:FW-1][0:FH-1];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic clear_stats();
        win_cnt = 0; eof_cnt = 0; ferr_cnt = 0;
        first_cx = -1; first_cy = -1; first_d00 = -1; first_dkk = -1;
        eof_cx = -1; eof_cy = -1;
        for (int i = 0; i < FW; i++) for (int j = 0; j < FH; j++) ph_seen[i][j] = -1;
    endtask

    // Drive one accepted pixel (called at negedge) and predict its effects.
    task automatic px(input logic [DATA_W-1:0] d, input bit sof, input int w, input int h, input int bs);
        bit   org;
        exp_t e;
        org      = (mx == 0 && my == 0);
        exp_ferr = sof ? !org : org;
        if (sof) begin mx = 0; my = 0; end
        if (sof || org) begin
            mw = w; mh = h;
            mcfg = (w < K) || (w > MAX_W) || (h < K) || (h > MAX_W);
        end
        img[my][mx] = d;
        if (mx >= K - 1 && my >= K - 1 && !mcfg) begin
            e.data = '0;
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++)
                    e.data[(r*K+c)*DATA_W +: DATA_W] = img[my-(K-1)+r][mx-(K-1)+c];
            e.cx  = CW'(mx - R);
            e.cy  = CW'(my - R);
            e.ph  = 2'(bs ^ (((my - R) % 2) * 2 + ((mx - R) % 2)));
            e.eof = (mx == mw - 1) && (my == mh - 1);
            q.push_back(e);
        end
        mx++;
        if (mx == mw) begin
            mx = 0; my++;
            if (my == mh) my = 0;
        end
        din = d; din_vld = 1'b1; din_sof = sof;
        h_active = CW'(w); v_active = CW'(h); bayer_start = 2'(bs);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        din_vld = 1'b0; din_sof = 1'b0; exp_ferr = 0;
        repeat (n) @(negedge clk);
    endtask

    task automatic frame(input int w, input int h, input int bs, input int gap, input bit rnd, input int npix);
        for (int i = 0; i < w * h && i < npix; i++) begin
            while (gap > 0 && $urandom_range(99) < gap) idle(1);
            px(rnd ? DATA_W'($urandom) : DATA_W'(i), i == 0, w, h, bs);
        end
    endtask

    task automatic drain(input string nm);
        idle(3);
        chk({nm, "_queue_drained"}, q.size(), 0);
    endtask

    // Monitor: sample just after each active edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n) begin
            if (win_vld) begin
                chk("vld_follows_accept", din_vld, 1);
                if (q.size() == 0) begin
                    chk("unexpected_window", 1, 0);
                end else begin
                    e = q.pop_front();
                    n_chk++;
                    if (win_data !== e.data || ctr_x !== e.cx || ctr_y !== e.cy ||
                        ctr_phase !== e.ph || win_eof !== e.eof) begin
                        n_fail++;
                        $display("FAIL window: got ctr=(%0d,%0d) ph=%0d eof=%0b data=%h expected ctr=(%0d,%0d) ph=%0d eof=%0b data=%h",
                                 ctr_x, ctr_y, ctr_phase, win_eof, win_data, e.cx, e.cy, e.ph, e.eof, e.data);
                    end
                    if (win_cnt == 0) begin
                        first_cx  = int'(ctr_x);
                        first_cy  = int'(ctr_y);
                        first_d00 = int'(win_data[DATA_W-1:0]);
                        first_dkk = int'(win_data[(K*K-1)*DATA_W +: DATA_W]);
                    end
                    if (win_eof) begin eof_cnt++; eof_cx = int'(ctr_x); eof_cy = int'(ctr_y); end
                    if (ctr_x < CW'(FW) && ctr_y < CW'(FH)) ph_seen[ctr_x][ctr_y] = int'(ctr_phase);
                    win_cnt++;
                end
            end
            if (frame_err || exp_ferr) chk("frame_err_cycle", frame_err, exp_ferr);
            if (frame_err) ferr_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_stats();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl_outputs", {ctr_x, ctr_y, ctr_phase, win_vld, win_eof, frame_err, cfg_err}, 0);
        chk("reset_win_data", |win_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // 1) continuous ramp frame
        clear_stats();
        frame(FW, FH, 0, 0, 0, FW * FH);
        drain("t1");
        chk("t1_win_count", win_cnt, NW);
        chk("t1_first_cx", first_cx, R);
        chk("t1_first_cy", first_cy, R);
        chk("t1_first_win00", first_d00, 0);
        chk("t1_first_winKK", first_dkk, (K - 1) * FW + (K - 1));
        chk("t1_eof_count", eof_cnt, 1);
        chk("t1_eof_cx", eof_cx, FW - 1 - R);
        chk("t1_eof_cy", eof_cy, FH - 1 - R);
        chk("t1_frame_err", ferr_cnt, 0);

        // 2) same ramp with 50% gaps, then random pixels with gaps
        clear_stats();
        frame(FW, FH, 0, 50, 0, FW * FH);
        drain("t2a");
        chk("t2_gap_win_count", win_cnt, NW);
        clear_stats();
        frame(FW, FH, 2, 30, 1, FW * FH);
        drain("t2b");
        chk("t2_rand_win_count", win_cnt, NW);
        chk("t2_frame_err", ferr_cnt, 0);

        // 3) GRBG phase
        clear_stats();
        frame(FW, FH, 1, 0, 0, FW * FH);
        drain("t3");
        chk("t3_phase_RR", ph_seen[R][R], 1 ^ ((R % 2) * 3));
        chk("t3_phase_R1R", ph_seen[R+1][R], 1 ^ ((R % 2) * 2 + ((R + 1) % 2)));
        chk("t3_phase_RR1", ph_seen[R][R+1], 1 ^ (((R + 1) % 2) * 2 + (R % 2)));

        // 4) early SOF at pixel 70
        frame(FW, FH, 0, 0, 0, 70);
        clear_stats();
        frame(FW, FH, 0, 0, 0, FW * FH);
        drain("t4");
        chk("t4_frame_err_pulses", ferr_cnt, 1);
        chk("t4_win_count", win_cnt, NW);
        chk("t4_eof_count", eof_cnt, 1);

        // 5) undersized width sets cfg_err; a legal frame clears it
        clear_stats();
        frame(3, FH, 0, 0, 0, 3 * FH);
        drain("t5a");
        chk("t5_cfg_err_set", cfg_err, 1);
        chk("t5_no_windows", win_cnt, 0);
        clear_stats();
        frame(FW, FH, 0, 0, 0, FW * FH);
        drain("t5b");
        chk("t5_cfg_err_clear", cfg_err, 0);
        chk("t5_win_count", win_cnt, NW);
        chk("t5_frame_err", ferr_cnt, 0);

        // 7) reset mid-frame
        frame(FW, FH, 0, 0, 0, 90);
        drain("t7a");
        rst_n = 1'b0;
        mx = 0; my = 0; mcfg = 0;
        @(posedge clk);
        #1;
        chk("t7_reset_ctrl_outputs", {ctr_x, ctr_y, ctr_phase, win_vld, win_eof, frame_err, cfg_err}, 0);
        chk("t7_reset_win_data", |win_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_stats();
        frame(FW, FH, 0, 0, 0, FW * FH);
        drain("t7b");
        chk("t7_frame_err", ferr_cnt, 0);
        chk("t7_win_count", win_cnt, NW);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
